vga_fetch: RTL and testbench
============================

// Module: vga_fetch
// PURPOSE
//  Requesting client of the memory_interface VGA read port. Issues vga_flag
//  reads, tracks accepted reads (done_vga) through the fixed read latency,
//  captures vga_pixel words into a small FIFO and unpacks each word into two
//  pixels for the VGA output stage. Absorbs arbitration stalls so display gets one pixel/cycle.
// PARAMETERS
//  MEM_W       36      memory word width (`LOG_MEM)
//  PIX_W       18      pixel width; word = {pixel0, pixel1}, MEM_W = 2*PIX_W
//  READ_LAT    2       cycles from done_vga to valid vga_pixel (read queue length)
//  FIFO_DEPTH  16      word FIFO depth, power of two
//  LOG_FIFO    4       log2(FIFO_DEPTH)
//  FRAME_WORDS 153600  words per frame (IMAGE_WIDTH*IMAGE_HEIGHT/2)
// PORTS
//  clock       in  1      system clock
//  reset       in  1      synchronous, active-low reset
//  frame_flag  in  1      start of frame; same pulse memory_interface receives
//  vga_flag    out 1      read request to memory_interface
//  done_vga    in  1      request accepted this cycle (address advanced)
//  vga_pixel   in  MEM_W  read data, valid exactly READ_LAT cycles after done_vga
//  pix_req     in  1      display consumes one pixel this cycle
//  pix_data    out PIX_W  pixel, registered
//  pix_valid   out 1      pix_data holds real pixel (0 = black/underflow filler)
//  underflow   out 1      sticky: pix_req seen with no pixel available
// BEHAVIOUR
//  Reset (reset==0 at edge): state IDLE; FIFO empty; inflight pipe cleared;
//   issued=0; half=0; vga_flag=0, pix_data=0, pix_valid=0, underflow=0.
//  States: IDLE -> FILL on frame_flag. FILL -> RUN when FIFO count+inflight
//   == FIFO_DEPTH or issued == FRAME_WORDS. RUN -> DONE when issued ==
//   FRAME_WORDS. Any state -> FILL on frame_flag (restart).
//  Request: vga_flag (combinational from regs) = state in {FILL,RUN} &&
//   (count + inflight) < FIFO_DEPTH && issued < FRAME_WORDS && !frame_flag.
//   done_vga only counts while vga_flag==1; done_vga without vga_flag is ignored.
//  inflight: READ_LAT-deep shift reg of done_vga bits; popcount = inflight.
//   Tail bit 1 -> push vga_pixel into FIFO same edge. Push never overflows
//   (guaranteed by request rule); overflow is an assertion failure.
//  issued: +1 per accepted done_vga, width ceil(log2(FRAME_WORDS+1)), no wrap.
//  Unpack: head word -> pixel0 = [MEM_W-1:PIX_W] when half=0, pixel1 =
//   [PIX_W-1:0] when half=1; pop word on consume with half=1; half toggles.
//  Output: pix_req in FILL or IDLE -> pix_valid=0, pix_data=0, no underflow.
//   pix_req in RUN/DONE with FIFO non-empty -> next edge pix_valid=1,
//   pix_data=pixel. Empty -> pix_valid=0, pix_data=0, underflow<=1.
//   No pix_req -> pix_valid<=0, pix_data holds.
//  Same-cycle push and pop on FIFO allowed; count unchanged; push into empty
//   FIFO not visible to pop until next cycle (no bypass).
//  frame_flag mid-frame: FIFO flushed, inflight pipe cleared (late data from
//   old frame discarded), issued=0, half=0, underflow=0, pix_valid=0;
//   vga_flag=0 that cycle; first new request next cycle.
//  DONE: no requests; drains FIFO; underflow rules still apply.
// CONFIGURATION
//  VGA_FETCH_STATS_EN defined: adds port underflow_count out 16, counts
//   underflow cycles in current frame, saturates at 16'hFFFF, cleared by
//   reset and frame_flag, registered. Undefined: port and counter absent;
//   all other behaviour identical.
// TESTING (FIFO_DEPTH=4, LOG_FIFO=2, READ_LAT=2, FRAME_WORDS=8)
//  1 reset=0 then 1, no frame_flag, pix_req=1 x5 -> vga_flag=0, pix_valid=0,
//    underflow=0 throughout.
//  2 frame_flag, done_vga=vga_flag always, vga_pixel=36'h00001_00002 +n -> 4
//    requests then stall; after FILL, pix_req stream gives 18'h00001,
//    18'h00002, ... in order, 16 pixels, no underflow.
//  3 done_vga held 0 for 10 cycles while RUN, pix_req=1 -> FIFO drains after
//    8 pixels, pix_valid=0, pix_data=0, underflow=1 sticky.
//  4 frame_flag 1 cycle after 2 requests accepted -> their returns discarded;
//    first pixel out is upper half of word returned for new frame request 0.
//  5 all 8 words issued -> vga_flag stays 0 (DONE); exactly 16 pix_valid.
//  6 STATS_EN, 3 underflow cycles then frame_flag -> underflow_count=3 then 0.

Source files
------------

// File: rtl/vga_fetch_if.sv
// Memory-side read port bundle between vga_fetch and memory_interface.
// Latency: n/a, wires only.
// Backpressure: requester holds vga_flag; memory accepts with done_vga when it wins arbitration.
//
// Signals:
//   vga_flag   requester -> memory   read request
//   done_vga   memory -> requester   request accepted this cycle
//   vga_pixel  memory -> requester   read data, valid a fixed latency after done_vga
interface vga_fetch_if #(
    parameter int MEM_W = 36
) ();
    logic             vga_flag;
    logic             done_vga;
    logic [MEM_W-1:0] vga_pixel;

    // master: the fetch client; slave: the memory arbiter
    modport master (output vga_flag, input done_vga, input vga_pixel);
    modport slave  (input vga_flag, output done_vga, output vga_pixel);
endinterface

// File: rtl/vga_fetch.sv
// VGA read client: issues frame reads, buffers returned words, streams two pixels per word.
// Latency: pixel registered one edge after pix_req; read data lands READ_LAT edges after done_vga.
// Backpressure: requests only while FIFO occupancy plus in-flight reads fits; starved pix_req flags underflow.
//
// Ports:
//   clock, reset     system clock, synchronous active-low reset
//   frame_flag       start-of-frame pulse (restarts fetch, flushes buffered data)
//   mem              vga_fetch_if.master: vga_flag out, done_vga in, vga_pixel in
//   pix_req          display consumes one pixel this cycle
//   pix_data         registered pixel (0 when no pixel available)
//   pix_valid        pix_data holds a real pixel
//   underflow        sticky per frame: pix_req seen with nothing to give
//   underflow_count  (only with VGA_FETCH_STATS_EN) saturating count of underflow cycles this frame
//
// Optional feature macro: VGA_FETCH_STATS_EN

// Small synchronous FIFO used for the word buffer. Flush has priority over push/pop.
// Latency: pushed word visible at head on the following cycle (no bypass).
// Backpressure: none internally; caller must never push full or pop empty (asserted).
module vga_fetch_fifo #(
    parameter int W     = 36,
    parameter int DEPTH = 16,
    parameter int LOG   = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         flush_i,
    input  logic         push_vld_i,
    input  logic [W-1:0] push_dat_i,
    input  logic         pop_vld_i,
    output logic [W-1:0] head_dat_o,
    output logic [LOG:0] count_o
);
    localparam logic [LOG:0] CNT_FULL = (LOG+1)'(DEPTH);

    logic [W-1:0]   store_q [DEPTH];
    logic [LOG-1:0] wr_ptr_q, wr_ptr_d;
    logic [LOG-1:0] rd_ptr_q, rd_ptr_d;
    logic [LOG:0]   count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_vld_i) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_vld_i)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push_vld_i && !pop_vld_i)
                count_d = count_q + 1'b1;
            else if (!push_vld_i && pop_vld_i)
                count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; the count gates every read of it.
    always_ff @(posedge clock) begin
        if (push_vld_i && !flush_i)
            store_q[wr_ptr_q] <= push_dat_i;
    end

    assign head_dat_o = store_q[rd_ptr_q];
    assign count_o    = count_q;

    a_no_overflow: assert property (@(posedge clock) disable iff (!reset)
        (push_vld_i && !pop_vld_i && !flush_i) |-> (count_q != CNT_FULL));
    a_no_underflow: assert property (@(posedge clock) disable iff (!reset)
        (pop_vld_i && !flush_i) |-> (count_q != '0));
endmodule

module vga_fetch #(
    parameter int MEM_W       = 36,
    parameter int PIX_W       = 18,
    parameter int READ_LAT    = 2,
    parameter int FIFO_DEPTH  = 16,
    parameter int LOG_FIFO    = 4,
    parameter int FRAME_WORDS = 153600
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             frame_flag,
    vga_fetch_if.master      mem,
    input  logic             pix_req,
    output logic [PIX_W-1:0] pix_data,
    output logic             pix_valid,
    output logic             underflow
`ifdef VGA_FETCH_STATS_EN
    ,
    output logic [15:0]      underflow_count
`endif
);
    localparam int ISS_W = $clog2(FRAME_WORDS + 1);
    // Wide enough for FIFO count plus every in-flight read.
    localparam int OCC_W = $clog2(FIFO_DEPTH + READ_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_RUN,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [READ_LAT-1:0] pipe_q, pipe_d;
    logic [ISS_W-1:0]    issued_q, issued_d;
    logic                half_q, half_d;
    logic [PIX_W-1:0]    pix_data_q, pix_data_d;
    logic                pix_valid_q, pix_valid_d;
    logic                underflow_q, underflow_d;

    logic [LOG_FIFO:0]   fifo_count;
    logic [MEM_W-1:0]    head_dat;
    logic [OCC_W-1:0]    inflight;
    logic [OCC_W-1:0]    occ;
    logic                req_ok;
    logic                accept;
    logic                fifo_empty;
    logic                disp_active;
    logic                serve;
    logic                starve;
    logic                pop;
    logic [PIX_W-1:0]    cur_pix;

    // Reads accepted but whose data has not yet landed in the FIFO.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LAT; i++)
            inflight = inflight + OCC_W'(pipe_q[i]);
    end

    assign occ = OCC_W'(fifo_count) + inflight;

    // Requesting is gated by reserved space, so a return can never find the FIFO full.
    // frame_flag suppresses the request so no read straddles the restart.
    assign req_ok = ((state_q == S_FILL) || (state_q == S_RUN))
                 && (occ < OCC_W'(FIFO_DEPTH))
                 && (issued_q < ISS_W'(FRAME_WORDS))
                 && !frame_flag;
    assign mem.vga_flag = req_ok;
    // done_vga outside a request is not ours to count.
    assign accept = req_ok && mem.done_vga;

    assign fifo_empty  = (fifo_count == '0);
    assign disp_active = (state_q == S_RUN) || (state_q == S_DONE);
    assign serve       = pix_req && disp_active && !fifo_empty && !frame_flag;
    assign starve      = pix_req && disp_active && fifo_empty && !frame_flag;
    // A word leaves the FIFO only once its second (low) pixel is consumed.
    assign pop         = serve && half_q;
    assign cur_pix     = half_q ? head_dat[PIX_W-1:0] : head_dat[MEM_W-1:PIX_W];

    vga_fetch_fifo #(
        .W     (MEM_W),
        .DEPTH (FIFO_DEPTH),
        .LOG   (LOG_FIFO)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .flush_i    (frame_flag),
        .push_vld_i (pipe_q[READ_LAT-1]),
        .push_dat_i (mem.vga_pixel),
        .pop_vld_i  (pop),
        .head_dat_o (head_dat),
        .count_o    (fifo_count)
    );

    always_comb begin
        state_d     = state_q;
        pipe_d      = '0;
        issued_d    = issued_q;
        half_d      = half_q;
        pix_data_d  = pix_data_q;
        pix_valid_d = 1'b0;
        underflow_d = underflow_q;

        case (state_q)
            S_IDLE: state_d = S_IDLE;
            S_FILL: begin
                if ((occ == OCC_W'(FIFO_DEPTH)) || (issued_q == ISS_W'(FRAME_WORDS)))
                    state_d = S_RUN;
            end
            S_RUN: begin
                if (issued_q == ISS_W'(FRAME_WORDS))
                    state_d = S_DONE;
            end
            S_DONE: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase

        if (frame_flag) begin
            // Restart: anything still in flight belongs to the old frame and is dropped.
            state_d     = S_FILL;
            pipe_d      = '0;
            issued_d    = '0;
            half_d      = 1'b0;
            underflow_d = 1'b0;
            if (pix_req)
                pix_data_d = '0;
        end else begin
            pipe_d[0] = accept;
            for (int i = 1; i < READ_LAT; i++)
                pipe_d[i] = pipe_q[i-1];
            issued_d = issued_q + ISS_W'(accept);
            if (serve) begin
                pix_valid_d = 1'b1;
                pix_data_d  = cur_pix;
                half_d      = ~half_q;
            end else if (pix_req) begin
                // Filler black pixel; only a running display counts it as underflow.
                pix_data_d = '0;
                if (starve)
                    underflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            pipe_q      <= '0;
            issued_q    <= '0;
            half_q      <= 1'b0;
            pix_data_q  <= '0;
            pix_valid_q <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pipe_q      <= pipe_d;
            issued_q    <= issued_d;
            half_q      <= half_d;
            pix_data_q  <= pix_data_d;
            pix_valid_q <= pix_valid_d;
            underflow_q <= underflow_d;
        end
    end

    assign pix_data  = pix_data_q;
    assign pix_valid = pix_valid_q;
    assign underflow = underflow_q;

`ifdef VGA_FETCH_STATS_EN
    logic [15:0] ucnt_q, ucnt_d;

    always_comb begin
        ucnt_d = ucnt_q;
        if (frame_flag)
            ucnt_d = '0;
        else if (starve && (ucnt_q != 16'hFFFF))
            ucnt_d = ucnt_q + 16'd1;
    end

    always_ff @(posedge clock) begin
        if (!reset)
            ucnt_q <= '0;
        else
            ucnt_q <= ucnt_d;
    end

    assign underflow_count = ucnt_q;
`endif
endmodule

// File: tb/tb_vga_fetch.sv
module tb_vga_fetch;
    logic        clock;
    logic        reset;
    logic        frame_flag;
    logic        pix_req;
    logic [17:0] pix_data;
    logic        pix_valid;
    logic        underflow;
`ifdef VGA_FETCH_STATS_EN
    logic [15:0] underflow_count;
`endif

    int          vectors;
    int          miscompares;
    logic        ack_auto;
    logic        flag_s;
    int          nreq;

    vga_fetch_if #(.MEM_W(36)) mem ();

    vga_fetch #(
        .MEM_W       (36),
        .PIX_W       (18),
        .READ_LAT    (2),
        .FIFO_DEPTH  (4),
        .LOG_FIFO    (2),
        .FRAME_WORDS (8)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .frame_flag (frame_flag),
        .mem        (mem),
        .pix_req    (pix_req),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .underflow  (underflow)
`ifdef VGA_FETCH_STATS_EN
        ,
        .underflow_count (underflow_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory model: accepted request n returns {2n+1, 2n+2} two cycles later.
    function automatic logic [35:0] word_of(input int unsigned n);
        word_of = {18'(2 * n + 1), 18'(2 * n + 2)};
    endfunction

    int unsigned req_n;
    logic [35:0] rd_pipe0, rd_pipe1;

    assign mem.done_vga  = ack_auto ? mem.vga_flag : 1'b0;
    assign mem.vga_pixel = rd_pipe1;

    initial begin
        req_n    = 0;
        rd_pipe0 = 36'hFFFFFFFFF;
        rd_pipe1 = 36'hFFFFFFFFF;
    end

    always @(posedge clock) begin
        if (mem.vga_flag && mem.done_vga) begin
            rd_pipe0 <= word_of(req_n);
            req_n    <= req_n + 1;
        end else begin
            rd_pipe0 <= 36'hFFFFFFFFF;
        end
        rd_pipe1 <= rd_pipe0;
    end

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: apply inputs, capture the request line, then step past the edge.
    task automatic cyc(input logic ff, input logic preq);
        frame_flag = ff;
        pix_req    = preq;
        #1;
        flag_s = mem.vga_flag;
        if (flag_s) nreq++;
        @(posedge clock);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        frame_flag  = 1'b0;
        pix_req     = 1'b0;
        ack_auto    = 1'b0;
        nreq        = 0;
        flag_s      = 1'b0;
        @(posedge clock);
        #1;
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        chk("rst_flag",  36'(mem.vga_flag), 36'd0);
        chk("rst_valid", 36'(pix_valid), 36'd0);
        chk("rst_data",  36'(pix_data), 36'd0);
        chk("rst_uflow", 36'(underflow), 36'd0);
        reset = 1'b1;

        // Idle: pix_req without a frame gives filler, no request, no underflow.
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b1);
            chk("idle_flag",  36'(flag_s), 36'd0);
            chk("idle_valid", 36'(pix_valid), 36'd0);
            chk("idle_data",  36'(pix_data), 36'd0);
            chk("idle_uflow", 36'(underflow), 36'd0);
        end

        // Frame 1 fill: flag low in the frame_flag cycle, 4 requests, then stall.
        ack_auto = 1'b1;
        nreq     = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(i == 0, 1'b0);
            chk("fill_flag", 36'(flag_s), 36'((i >= 1) && (i <= 4)));
        end
        // Whole frame streamed: pixels 1..16 with no gap.
        for (int k = 1; k <= 16; k++) begin
            cyc(1'b0, 1'b1);
            chk("stream_valid", 36'(pix_valid), 36'd1);
            chk("stream_data",  36'(pix_data), 36'(k));
            chk("stream_uflow", 36'(underflow), 36'd0);
        end
        chk("frame_reqs", 36'(nreq), 36'd8);
        // DONE: no more requests, data held while idle.
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0);
            chk("done_flag",  36'(flag_s), 36'd0);
            chk("done_valid", 36'(pix_valid), 36'd0);
            chk("done_hold",  36'(pix_data), 36'd16);
        end
        chk("done_reqs", 36'(nreq), 36'd8);

        // Frame 2: fill, then stall memory and drain into underflow.
        for (int i = 0; i < 8; i++) cyc(i == 0, 1'b0);
        ack_auto = 1'b0;
        for (int k = 0; k < 11; k++) begin
            cyc(1'b0, 1'b1);
            if (k < 8) begin
                chk("drain_valid", 36'(pix_valid), 36'd1);
                chk("drain_data",  36'(pix_data), 36'(17 + k));
                chk("drain_uflow", 36'(underflow), 36'd0);
            end else begin
                chk("starve_valid", 36'(pix_valid), 36'd0);
                chk("starve_data",  36'(pix_data), 36'd0);
                chk("starve_uflow", 36'(underflow), 36'd1);
`ifdef VGA_FETCH_STATS_EN
                chk("starve_count", 36'(underflow_count), 36'(k - 7));
`endif
            end
        end
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, 1'b0);
            chk("sticky_uflow", 36'(underflow), 36'd1);
            chk("sticky_valid", 36'(pix_valid), 36'd0);
        end

        // Frame 3: restart clears underflow; a second restart after two accepts drops their data.
        ack_auto = 1'b1;
        cyc(1'b1, 1'b0);
        chk("restart_uflow", 36'(underflow), 36'd0);
        chk("restart_valid", 36'(pix_valid), 36'd0);
`ifdef VGA_FETCH_STATS_EN
        chk("restart_count", 36'(underflow_count), 36'd0);
`endif
        cyc(1'b0, 1'b0);
        chk("pre_req0", 36'(flag_s), 36'd1);
        cyc(1'b0, 1'b0);
        chk("pre_req1", 36'(flag_s), 36'd1);
        cyc(1'b1, 1'b0);
        chk("restart_flag", 36'(flag_s), 36'd0);
        for (int i = 1; i < 8; i++) begin
            cyc(1'b0, 1'b0);
            chk("refill_flag", 36'(flag_s), 36'(i <= 4));
        end
        // First request after restart was global request 14 -> pixels 29, 30, 31, 32.
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 1'b1);
            chk("new_valid", 36'(pix_valid), 36'd1);
            chk("new_data",  36'(pix_data), 36'(29 + k));
        end
        cyc(1'b0, 1'b0);
        chk("hold_valid", 36'(pix_valid), 36'd0);
        chk("hold_data",  36'(pix_data), 36'd32);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
